// File: rtl/wb_stage_if.sv
// Memory-stage-to-writeback handshake plus register-file write port of wb_stage.
// master = upstream memory stage side, slave = the writeback stage itself.
interface wb_stage_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready never depends on in_valid, and in_valid/payload are sampled only then.
    logic          in_valid;
    logic          in_ready;
    logic          in_we;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_mem;
    logic          in_sel_mem;
    logic          in_sp_inc;
    logic          in_sp_dec;
    logic          flush;

    logic          rf_we;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic          rf_sp_inc;
    logic          rf_sp_dec;

    modport master (
        output in_valid, in_we, in_rd, in_alu, in_mem, in_sel_mem,
               in_sp_inc, in_sp_dec, flush,
        input  in_ready, rf_we, rf_wr_addr, rf_wr_data, rf_sp_inc, rf_sp_dec
    );

    modport slave (
        input  in_valid, in_we, in_rd, in_alu, in_mem, in_sel_mem,
               in_sp_inc, in_sp_dec, flush,
        output in_ready, rf_we, rf_wr_addr, rf_wr_data, rf_sp_inc, rf_sp_dec
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers one retiring instruction and drives the register-file write
// port and SP controls. Defining WB_FWD_EN adds the fwd_* bypass tap.
module wb_stage #(
    parameter int DW      = 8,
    parameter int AW      = 2,
    parameter int SP_ADDR = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_stage_if.slave     bus,
    output logic          busy,
    output logic [1:0]    dbg_state
`ifdef WB_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [AW-1:0] fwd_addr,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam logic [AW-1:0] SP_IDX = AW'(SP_ADDR);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WB       = 2'd1,
        S_SPLIT_SP = 2'd2,
        S_SPLIT_WR = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_wr_addr_q, rf_wr_addr_d;
    logic [DW-1:0] rf_wr_data_q, rf_wr_data_d;
    logic          rf_sp_inc_q, rf_sp_inc_d;
    logic          rf_sp_dec_q, rf_sp_dec_d;

    logic          in_ready_c;
    logic          transfer;
    logic [DW-1:0] cap_data;
    logic          cap_inc;
    logic          cap_dec;
    logic          conflict;

    // SPLIT_SP must always be followed by SPLIT_WR, so nothing new may enter there.
    always_comb begin
        in_ready_c = rst_n && !bus.flush && (state_q != S_SPLIT_SP);
        transfer   = bus.in_valid && in_ready_c;
        cap_data   = bus.in_sel_mem ? bus.in_mem : bus.in_alu;
        cap_inc    = bus.in_sp_inc;
        cap_dec    = bus.in_sp_dec && !bus.in_sp_inc;
        conflict   = bus.in_we && (bus.in_rd == SP_IDX) && (cap_inc || cap_dec);
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rf_we_d      = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_sp_inc_d  = 1'b0;
        rf_sp_dec_d  = 1'b0;
        case (state_q)
            S_SPLIT_SP: begin
                // Flush is ignored here so the R3 write of a split instruction always lands.
                state_d      = S_SPLIT_WR;
                rf_we_d      = 1'b1;
                rf_wr_addr_d = SP_IDX;
                rf_wr_data_d = data_q;
            end
            default: begin
                if (transfer) begin
                    data_d      = cap_data;
                    rf_sp_inc_d = cap_inc;
                    rf_sp_dec_d = cap_dec;
                    if (conflict) begin
                        state_d = S_SPLIT_SP;
                    end else begin
                        state_d = S_WB;
                        rf_we_d = bus.in_we;
                        if (bus.in_we) begin
                            rf_wr_addr_d = bus.in_rd;
                            rf_wr_data_d = cap_data;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            rf_we_q      <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            rf_sp_inc_q  <= 1'b0;
            rf_sp_dec_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            rf_we_q      <= rf_we_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_sp_inc_q  <= rf_sp_inc_d;
            rf_sp_dec_q  <= rf_sp_dec_d;
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wr_addr = rf_wr_addr_q;
    assign bus.rf_wr_data = rf_wr_data_q;
    assign bus.rf_sp_inc  = rf_sp_inc_q;
    assign bus.rf_sp_dec  = rf_sp_dec_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;

`ifdef WB_FWD_EN
    assign fwd_valid = rf_we_q;
    assign fwd_addr  = rf_wr_addr_q;
    assign fwd_data  = rf_wr_data_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed test-plan steps then randomized traffic,
// checked against an instruction-level model and a small register file fed by the DUT.
module tb_wb_stage;
  localparam int DW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_stage_if #(.DW(DW), .AW(AW)) bus ();
  logic       busy;
  logic [1:0] dbg_state;
`ifdef WB_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
`endif

  wb_stage #(.DW(DW), .AW(AW), .SP_ADDR(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data)
`endif
  );

  // Register file consuming the DUT outputs: SP inc/dec beats a same-cycle R3 write.
  logic [DW-1:0] tb_rf [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_rf[0] <= 8'h00;
      tb_rf[1] <= 8'h00;
      tb_rf[2] <= 8'h00;
      tb_rf[3] <= 8'hFF;
    end else begin
      if (bus.rf_we && !(bus.rf_wr_addr == 2'd3 && (bus.rf_sp_inc || bus.rf_sp_dec)))
        tb_rf[bus.rf_wr_addr] <= bus.rf_wr_data;
      if (bus.rf_sp_inc)      tb_rf[3] <= tb_rf[3] + 8'd1;
      else if (bus.rf_sp_dec) tb_rf[3] <= tb_rf[3] - 8'd1;
    end
  end

  // Reference model: each accepted instruction becomes one or two commit actions.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          inc;
    logic          dec;
  } act_t;

  act_t          exp_q[$];
  logic [DW-1:0] m_rf [4];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_addr = '0;
    last_data = '0;
    m_rf[0] = 8'h00; m_rf[1] = 8'h00; m_rf[2] = 8'h00; m_rf[3] = 8'hFF;
  endtask

  task automatic model_accept(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] data,
                              input logic inc, input logic dec_raw);
    logic dec;
    act_t a;
    dec = dec_raw && !inc;
    if (we && rd == 2'd3 && (inc || dec)) begin
      a = '{we: 1'b0, addr: '0, data: '0, inc: inc, dec: dec};
      exp_q.push_back(a);
      a = '{we: 1'b1, addr: 2'd3, data: data, inc: 1'b0, dec: 1'b0};
      exp_q.push_back(a);
    end else begin
      a = '{we: we, addr: rd, data: data, inc: inc, dec: dec};
      exp_q.push_back(a);
    end
    if (inc)      m_rf[3] = m_rf[3] + 8'd1;
    else if (dec) m_rf[3] = m_rf[3] - 8'd1;
    if (we) m_rf[rd] = data;
  endtask

  task automatic check_outputs();
    act_t a;
    logic exp_busy;
    if (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      a = '0;
      exp_busy = 1'b0;
    end
    if (a.we) begin
      last_addr = a.addr;
      last_data = a.data;
    end
    check("rf_we", bus.rf_we, a.we);
    check("rf_sp_inc", bus.rf_sp_inc, a.inc);
    check("rf_sp_dec", bus.rf_sp_dec, a.dec);
    check("rf_wr_addr", bus.rf_wr_addr, last_addr);
    check("rf_wr_data", bus.rf_wr_data, last_data);
    check("busy", busy, exp_busy);
    check("dbg_state_busy", dbg_state != 2'd0, exp_busy);
`ifdef WB_FWD_EN
    check("fwd_valid", fwd_valid, a.we);
    check("fwd_addr", fwd_addr, last_addr);
    check("fwd_data", fwd_data, last_data);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"}, bus.rf_we, 1'b0);
    check({tag, "_rf_sp_inc"}, bus.rf_sp_inc, 1'b0);
    check({tag, "_rf_sp_dec"}, bus.rf_sp_dec, 1'b0);
    check({tag, "_rf_wr_addr"}, bus.rf_wr_addr, 2'd0);
    check({tag, "_rf_wr_data"}, bus.rf_wr_data, 8'h00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic sel,
                       input logic inc, input logic dec, input logic fl);
    bus.in_valid = v;   bus.in_we = we;       bus.in_rd = rd;
    bus.in_alu = alu;   bus.in_mem = mem;     bus.in_sel_mem = sel;
    bus.in_sp_inc = inc; bus.in_sp_dec = dec; bus.flush = fl;
  endtask

  // One clock cycle: drive, check in_ready, update model, cross the edge, check outputs.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic sel,
                       input logic inc, input logic dec, input logic fl);
    logic exp_ready;
    drive(v, we, rd, alu, mem, sel, inc, dec, fl);
    #1;
    exp_ready = !fl && (exp_q.size() == 0);
    check("in_ready", bus.in_ready, exp_ready);
    if (v && exp_ready) model_accept(we, rd, sel ? mem : alu, inc, dec);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain_and_compare(input string tag);
    int guard = 0;
    while (exp_q.size() > 0 && guard < 8) begin
      idle();
      guard++;
    end
    idle();
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_r%0d", tag, i), tb_rf[i], m_rf[i]);
  endtask

  initial begin
    model_reset();
    apply_reset("reset");

    // Normal ALU write to R1; in_ready must be 1 in the first cycle after reset.
    cycle(1'b1, 1'b1, 2'd1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("normal_data", bus.rf_wr_data, 8'h5A);
    drain_and_compare("normal");
    check("normal_r1", tb_rf[1], 8'h5A);

    // Memory select then ALU, back to back.
    cycle(1'b1, 1'b1, 2'd2, 8'hEE, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'd0, 8'h11, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_second_addr", bus.rf_wr_addr, 2'd0);
    drain_and_compare("b2b");

    // SP conflict: dec SP and write R3; write wins.
    cycle(1'b1, 1'b1, 2'd3, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("conflict_sp_dec", bus.rf_sp_dec, 1'b1);
    cycle(1'b1, 1'b1, 2'd1, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("conflict_wr_data", bus.rf_wr_data, 8'h80);
    drain_and_compare("conflict");
    check("conflict_r3", tb_rf[3], 8'h80);

    // Flush while an R1 entry is held.
    cycle(1'b1, 1'b1, 2'd1, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'd2, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_and_compare("flush_wb");

    // Flush during SPLIT_SP: R3 write still lands.
    cycle(1'b1, 1'b1, 2'd3, 8'hC3, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 2'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    drain_and_compare("flush_split");
    check("flush_split_r3", tb_rf[3], 8'hC3);

    // SP = 0xFF, then inc+dec with no write: inc wins and SP wraps to 0.
    cycle(1'b1, 1'b1, 2'd3, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    check("incdec_inc", bus.rf_sp_inc, 1'b1);
    drain_and_compare("incdec");
    check("incdec_r3", tb_rf[3], 8'h00);

    // Reset in the middle of a split abandons the write phase.
    cycle(1'b1, 1'b1, 2'd3, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_reset("reset_mid_split");
    drain_and_compare("after_reset");

    // Randomized traffic with occasional flush and one reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) apply_reset("reset_random");
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)),
            DW'($urandom), DW'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      if (n % 50 == 49) drain_and_compare("random");
    end
    drain_and_compare("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
